// File: rtl/fifo_ctrl_if.sv
// Request/grant and pointer bundle between fifo_ctrl and its buffer users.
// The master drives requests and flush; the slave (fifo_ctrl) returns grants, pointers and status.
interface fifo_ctrl_if;
  logic       store_tx_req;
  logic       get_rx_req;
  logic       store_rx_req;
  logic       get_tx_req;
  logic       flush;
  logic [6:0] store_ptr;
  logic [6:0] get_ptr;
  logic       store_tx_data;
  logic       store_rx_packet_data;
  logic       get_rx_gnt;
  logic       get_tx_gnt;
  logic [1:0] owner;
  logic [6:0] count;
  logic       full;
  logic       empty;
  logic       overflow_err;
  logic       underflow_err;
  logic       dir_err;

  modport master (
    output store_tx_req, get_rx_req, store_rx_req, get_tx_req, flush,
    input  store_ptr, get_ptr, store_tx_data, store_rx_packet_data,
           get_rx_gnt, get_tx_gnt, owner, count, full, empty,
           overflow_err, underflow_err, dir_err
  );

  modport slave (
    input  store_tx_req, get_rx_req, store_rx_req, get_tx_req, flush,
    output store_ptr, get_ptr, store_tx_data, store_rx_packet_data,
           get_rx_gnt, get_tx_gnt, owner, count, full, empty,
           overflow_err, underflow_err, dir_err
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer manager and direction arbiter for the 64-entry shared data buffer.
// state   | meaning
// IDLE    | buffer empty, first store request claims direction
// RX_FILL | USB RX fills, AHB reads drain
// TX_FILL | AHB writes fill, USB TX reads drain
module fifo_ctrl (
  input logic        clk,
  input logic        n_rst,
  fifo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RX_FILL = 2'b01,
    TX_FILL = 2'b10
  } owner_t;

  owner_t     state;
  owner_t     next_state;
  logic [6:0] store_ptr;
  logic [6:0] get_ptr;
  logic [6:0] count;
  logic [6:0] next_count;
  logic       full;
  logic       empty;
  logic       st_tx;
  logic       st_rx;
  logic       g_rx;
  logic       g_tx;
  logic       ovf_c;
  logic       unf_c;
  logic       dir_c;
  logic       overflow_err;
  logic       underflow_err;
  logic       dir_err;

  // Pointers carry one wrap bit, so the difference spans 0..64 without ambiguity.
  assign count = store_ptr - get_ptr;
  assign full  = (count == 7'd64);
  assign empty = (count == 7'd0);

  always_comb begin
    st_tx      = 1'b0;
    st_rx      = 1'b0;
    g_rx       = 1'b0;
    g_tx       = 1'b0;
    ovf_c      = 1'b0;
    unf_c      = 1'b0;
    dir_c      = 1'b0;
    next_state = state;
    if (!n_rst && !bus.flush) begin
      case (state)
        IDLE: begin
          // RX wins a simultaneous claim; reads have nothing to drain yet.
          dir_c = (bus.store_rx_req & bus.store_tx_req) | bus.get_rx_req | bus.get_tx_req;
          if (bus.store_rx_req) begin
            if (!full) begin
              st_rx      = 1'b1;
              next_state = RX_FILL;
            end else begin
              ovf_c = 1'b1;
            end
          end else if (bus.store_tx_req) begin
            if (!full) begin
              st_tx      = 1'b1;
              next_state = TX_FILL;
            end else begin
              ovf_c = 1'b1;
            end
          end
        end
        RX_FILL: begin
          st_rx = bus.store_rx_req & ~full;
          ovf_c = bus.store_rx_req & full;
          g_rx  = bus.get_rx_req & ~empty;
          unf_c = bus.get_rx_req & empty;
          dir_c = bus.store_tx_req | bus.get_tx_req;
        end
        TX_FILL: begin
          st_tx = bus.store_tx_req & ~full;
          ovf_c = bus.store_tx_req & full;
          g_tx  = bus.get_tx_req & ~empty;
          unf_c = bus.get_tx_req & empty;
          dir_c = bus.store_rx_req | bus.get_rx_req;
        end
        default: next_state = IDLE;
      endcase
    end
    next_count = count + {6'd0, st_tx | st_rx} - {6'd0, g_rx | g_tx};
    if (next_count == 7'd0) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      store_ptr     <= 7'd0;
      get_ptr       <= 7'd0;
      state         <= IDLE;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      dir_err       <= 1'b0;
    end else if (bus.flush) begin
      store_ptr     <= 7'd0;
      get_ptr       <= 7'd0;
      state         <= IDLE;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      dir_err       <= 1'b0;
    end else begin
      if (st_tx | st_rx) store_ptr <= store_ptr + 7'd1;
      if (g_rx | g_tx)   get_ptr   <= get_ptr + 7'd1;
      state         <= next_state;
      overflow_err  <= ovf_c;
      underflow_err <= unf_c;
      dir_err       <= dir_c;
    end
  end

  assign bus.store_ptr            = store_ptr;
  assign bus.get_ptr              = get_ptr;
  assign bus.store_tx_data        = st_tx;
  assign bus.store_rx_packet_data = st_rx;
  assign bus.get_rx_gnt           = g_rx;
  assign bus.get_tx_gnt           = g_tx;
  assign bus.owner                = state;
  assign bus.count                = count;
  assign bus.full                 = full;
  assign bus.empty                = empty;
  assign bus.overflow_err         = overflow_err;
  assign bus.underflow_err        = underflow_err;
  assign bus.dir_err              = dir_err;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: the driver queues hand-computed expectations per cycle,
// a separate monitor compares them against the DUT at the falling edge.
module tb_fifo_ctrl;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  fifo_ctrl_if bus ();

  fifo_ctrl u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string      nm;
    logic [3:0] gnt;  // {store_tx_data, store_rx_packet_data, get_rx_gnt, get_tx_gnt}
    logic [6:0] sp;
    logic [6:0] gp;
    logic [1:0] own;
    logic [2:0] err;  // {overflow_err, underflow_err, dir_err}
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req bits use the grant order: {store_tx, store_rx, get_rx, get_tx}
  task automatic drv(input logic [3:0] req, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus.store_tx_req = req[3];
    bus.store_rx_req = req[2];
    bus.get_rx_req   = req[1];
    bus.get_tx_req   = req[0];
    bus.flush        = fl;
    n_rst            = rs;
  endtask

  // Expected pointers/owner/errors are the values visible during this cycle (pre-edge).
  task automatic cyc(input string nm, input logic [3:0] req, input logic fl, input logic rs,
                     input logic [3:0] eg, input logic [6:0] esp, input logic [6:0] egp,
                     input logic [1:0] eown, input logic [2:0] eerr);
    exp_t e;
    drv(req, fl, rs);
    e.nm  = nm;
    e.gnt = eg;
    e.sp  = esp;
    e.gp  = egp;
    e.own = eown;
    e.err = eerr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] ag;
    logic [2:0] ae;
    logic [6:0] ecnt;
    logic       efull;
    logic       eempty;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e      = q.pop_front();
        ag     = {bus.store_tx_data, bus.store_rx_packet_data, bus.get_rx_gnt, bus.get_tx_gnt};
        ae     = {bus.overflow_err, bus.underflow_err, bus.dir_err};
        ecnt   = e.sp - e.gp;
        efull  = (ecnt == 7'd64);
        eempty = (ecnt == 7'd0);
        checks++;
        if (ag !== e.gnt || bus.store_ptr !== e.sp || bus.get_ptr !== e.gp ||
            bus.owner !== e.own || ae !== e.err || bus.count !== ecnt ||
            bus.full !== efull || bus.empty !== eempty) begin
          errors++;
          $display("FAIL %s: got gnt=%b sp=%0d gp=%0d own=%b err=%b cnt=%0d full=%b empty=%b; want gnt=%b sp=%0d gp=%0d own=%b err=%b cnt=%0d full=%b empty=%b",
                   e.nm, ag, bus.store_ptr, bus.get_ptr, bus.owner, ae, bus.count, bus.full, bus.empty,
                   e.gnt, e.sp, e.gp, e.own, e.err, ecnt, efull, eempty);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    n_rst  = 1'b1;
    bus.store_tx_req = 1'b0;
    bus.store_rx_req = 1'b0;
    bus.get_rx_req   = 1'b0;
    bus.get_tx_req   = 1'b0;
    bus.flush        = 1'b0;

    // Reset with a store request held: grants forced low.
    drv(4'b0100, 1'b0, 1'b1);
    drv(4'b0100, 1'b0, 1'b1);
    cyc("rst_state", 4'b0100, 1'b0, 1'b1, 4'b0000, 7'd0, 7'd0, 2'b00, 3'b000);

    // RX fill of three bytes, then three AHB reads.
    cyc("rx_st0", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'd0, 7'd0, 2'b00, 3'b000);
    cyc("rx_st1", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'd1, 7'd0, 2'b01, 3'b000);
    cyc("rx_st2", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'd2, 7'd0, 2'b01, 3'b000);
    cyc("rx_g0",  4'b0010, 1'b0, 1'b0, 4'b0010, 7'd3, 7'd0, 2'b01, 3'b000);
    cyc("rx_g1",  4'b0010, 1'b0, 1'b0, 4'b0010, 7'd3, 7'd1, 2'b01, 3'b000);
    cyc("rx_g2",  4'b0010, 1'b0, 1'b0, 4'b0010, 7'd3, 7'd2, 2'b01, 3'b000);
    cyc("rx_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 7'd3, 7'd3, 2'b00, 3'b000);

    // TX fill to full, overflow, then store+get at full.
    for (int i = 0; i < 64; i++)
      cyc("tx_fill", 4'b1000, 1'b0, 1'b0, 4'b1000, 7'(3 + i), 7'd3, (i == 0) ? 2'b00 : 2'b10, 3'b000);
    cyc("tx_ovf",       4'b1000, 1'b0, 1'b0, 4'b0000, 7'd67, 7'd3, 2'b10, 3'b000);
    cyc("tx_full_both", 4'b1001, 1'b0, 1'b0, 4'b0001, 7'd67, 7'd3, 2'b10, 3'b100);
    cyc("tx_after",     4'b0000, 1'b0, 1'b0, 4'b0000, 7'd67, 7'd4, 2'b10, 3'b100);
    for (int i = 0; i < 63; i++)
      cyc("tx_drain", 4'b0001, 1'b0, 1'b0, 4'b0001, 7'd67, 7'(4 + i), 2'b10, 3'b000);

    // Sustained store+get to walk the pointers to 120/120.
    cyc("tp_claim", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'd67, 7'd67, 2'b00, 3'b000);
    for (int i = 0; i < 52; i++)
      cyc("tp_both", 4'b0110, 1'b0, 1'b0, 4'b0110, 7'(68 + i), 7'(67 + i), 2'b01, 3'b000);
    cyc("tp_last", 4'b0010, 1'b0, 1'b0, 4'b0010, 7'd120, 7'd119, 2'b01, 3'b000);

    // Ten TX stores across the pointer wrap.
    for (int i = 0; i < 10; i++)
      cyc("wrap_st", 4'b1000, 1'b0, 1'b0, 4'b1000, 7'(120 + i), 7'd120, (i == 0) ? 2'b00 : 2'b10, 3'b000);
    cyc("wrap_chk", 4'b0000, 1'b0, 1'b0, 4'b0000, 7'd2, 7'd120, 2'b10, 3'b000);
    for (int i = 0; i < 10; i++)
      cyc("wrap_dr", 4'b0001, 1'b0, 1'b0, 4'b0001, 7'd2, 7'(120 + i), 2'b10, 3'b000);

    // Simultaneous claim: RX wins, TX flagged; wrong-side read later.
    cyc("both_claim", 4'b1100, 1'b0, 1'b0, 4'b0100, 7'd2, 7'd2, 2'b00, 3'b000);
    cyc("dir_gtx",    4'b0001, 1'b0, 1'b0, 4'b0000, 7'd3, 7'd2, 2'b01, 3'b001);
    cyc("dir_chk",    4'b0000, 1'b0, 1'b0, 4'b0000, 7'd3, 7'd2, 2'b01, 3'b001);
    cyc("dir_clr",    4'b0010, 1'b0, 1'b0, 4'b0010, 7'd3, 7'd2, 2'b01, 3'b000);

    // Flush at count 17 with requests active.
    for (int i = 0; i < 17; i++)
      cyc("fl_fill", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'(3 + i), 7'd3, (i == 0) ? 2'b00 : 2'b01, 3'b000);
    cyc("flush",   4'b0110, 1'b1, 1'b0, 4'b0000, 7'd20, 7'd3, 2'b01, 3'b000);
    cyc("fl_chk",  4'b0000, 1'b0, 1'b0, 4'b0000, 7'd0, 7'd0, 2'b00, 3'b000);

    // Read while idle is a direction error.
    cyc("idle_rd",     4'b0010, 1'b0, 1'b0, 4'b0000, 7'd0, 7'd0, 2'b00, 3'b000);
    cyc("idle_rd_chk", 4'b0000, 1'b0, 1'b0, 4'b0000, 7'd0, 7'd0, 2'b00, 3'b001);

    // Reset mid-transfer with an error pulse pending.
    for (int i = 0; i < 5; i++)
      cyc("rs_fill", 4'b0100, 1'b0, 1'b0, 4'b0100, 7'(i), 7'd0, (i == 0) ? 2'b00 : 2'b01, 3'b000);
    cyc("rs_err",    4'b0101, 1'b0, 1'b0, 4'b0100, 7'd5, 7'd0, 2'b01, 3'b000);
    cyc("rs_assert", 4'b0111, 1'b0, 1'b1, 4'b0000, 7'd6, 7'd0, 2'b01, 3'b001);
    cyc("rs_chk",    4'b0000, 1'b0, 1'b0, 4'b0000, 7'd0, 7'd0, 2'b00, 3'b000);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
